mips_multicycle_sequencer: RTL and testbench
============================================

MIPS_MULTICYCLE_SEQUENCER -- requirements
Module: mips_multicycle_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for a memory ready before error.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, begins or resumes execution from IDLE/HALT.
REQ-005 SHALL have port halt_req, input, 1, stop after the current instruction completes.
REQ-006 SHALL have port imem_ready, input, 1, instruction memory returns the word this cycle.
REQ-007 SHALL have port dmem_ready, input, 1, data memory access completes this cycle.
REQ-008 SHALL have port ctl_mem_read / ctl_mem_write / ctl_reg_write / ctl_branch / ctl_jump, inputs, 1 each, control-unit decode of the current instruction.
REQ-009 SHALL have port zero_bit, input, 1, ALU zero flag.
REQ-010 SHALL have port imem_req, output, 1, fetch request.
REQ-011 SHALL have port ir_write, output, 1, instruction-register load strobe.
REQ-012 SHALL have port dmem_read / dmem_write, outputs, 1 each, data-memory strobes.
REQ-013 SHALL have port reg_write, output, 1, register-file write strobe, single-cycle pulse.
REQ-014 SHALL have port pc_write, output, 1, PC update strobe; pc_src, output, 2, 00 PC+1, 01 branch target, 10 jump target.
REQ-015 SHALL have port state, output, 3, current FSM state; error, output, 1, sticky fault flag.
REQ-016 SHALL have ports instr_count / cycle_count, outputs, 32 each, performance counters (see Configuration).

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR; all outputs Moore-decoded from state plus ready/decode inputs.
REQ-018 IDLE/HALT: start=1 -> FETCH; otherwise hold.
REQ-019 FETCH: imem_req=1; on imem_ready=1 pulse ir_write, -> DECODE.
REQ-020 DECODE: exactly one cycle -> EXEC.
REQ-021 EXEC: ctl_jump -> pc_write, pc_src=10; else ctl_branch -> pc_write, pc_src=(zero_bit?01:00); else mem access -> MEM; else ctl_reg_write -> WB; else pc_write, pc_src=00.
REQ-022 EXEC with ctl_mem_read=1 and ctl_mem_write=1 simultaneously -> ERR, no strobes issued.
REQ-023 MEM: assert dmem_read or dmem_write until dmem_ready; then read -> WB, write -> pc_write, pc_src=00.
REQ-024 WB: reg_write=1 and pc_write=1, pc_src=00, same cycle.
REQ-025 After any pc_write cycle: halt_req=1 -> HALT, else -> FETCH; halt_req elsewhere ignored.
REQ-026 Latency with zero-wait memory: R-type 4, lw 5, sw 4, branch/jump 3 cycles.
REQ-027 Wait counter clears on entry to FETCH/MEM; reaching MEM_TIMEOUT consecutive not-ready cycles -> ERR.
REQ-028 ERR: error=1, all strobes 0; exits only via reset_n.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, all strobes 0, error=0, counters 0.
REQ-030 Reset mid-access SHALL drop dmem/imem strobes immediately; no partial reg_write or pc_write.

Configuration
REQ-031 With MIPS_SEQ_PERF_EN defined: cycle_count increments every cycle outside IDLE/HALT/ERR; instr_count increments per pc_write; both saturate at 32'hFFFFFFFF.
REQ-032 Without MIPS_SEQ_PERF_EN: instr_count and cycle_count SHALL be tied to 0, no counter flops.

Structure
REQ-033 Package mips_seq_pkg SHALL hold state encodings and pc_src constants (PC_SRC_SEQ, PC_SRC_BRANCH, PC_SRC_JUMP).
REQ-034 Sub-module mips_seq_wait_timer SHALL implement the wait counter/timeout compare.

Verification
REQ-035 reset, start=1, R-type decode, ready always 1 -> reg_write and pc_write pulse together in cycle 4, instr_count=1.
REQ-036 lw with dmem_ready delayed 3 cycles -> dmem_read held 4 cycles, reg_write in WB, total 8 cycles.
REQ-037 branch, zero_bit=1 -> pc_src=01 in cycle 3; zero_bit=0 -> pc_src=00.
REQ-038 imem_ready stuck 0 for 15 cycles -> ERR, error=1, imem_req=0.
REQ-039 halt_req=1 during sw -> HALT after pc_write; start=1 -> FETCH next cycle.
REQ-040 reset_n low during MEM -> dmem_write=0 same cycle, state=IDLE, counters 0.

Source files
------------

// File: rtl/mips_seq_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: FSM state codes,
// PC source select values and a saturating counter helper.
package mips_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mips_seq_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait and flags a timeout
// on the MEM_TIMEOUT-th such cycle, so the FSM can leave on that same edge.
module mips_seq_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic waiting,
    output logic timeout
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count;

    // Count not-ready cycles; restart whenever a new wait state is entered.
    // NOTE: every flop is written with <= so all state updates see the pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (waiting && !timeout) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = waiting && (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with halt,
// memory-wait timeout and a sticky error state.
// Optional feature: define MIPS_SEQ_PERF_EN to build the saturating
// instr_count/cycle_count performance counters; otherwise they read 0.
module mips_multicycle_sequencer
    import mips_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        ctl_mem_read,
    input  logic        ctl_mem_write,
    input  logic        ctl_reg_write,
    input  logic        ctl_branch,
    input  logic        ctl_jump,
    input  logic        zero_bit,
    output logic        imem_req,
    output logic        ir_write,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        reg_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  state,
    output logic        error,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    logic [2:0] state_q;
    logic [2:0] next_state;
    logic       mem_is_write_q;
    logic       wait_clear;
    logic       waiting;
    logic       timeout;

    assign state = state_q;
    assign error = (state_q == ST_ERR);

    // Next-state and strobe decode; strobes depend only on state plus live inputs.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    next_state = ST_DECODE;
                end else if (timeout) begin
                    next_state = ST_ERR;
                end
            end
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC: begin
                if (ctl_mem_read && ctl_mem_write) begin
                    next_state = ST_ERR;
                end else if (ctl_jump) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                end else if (ctl_branch) begin
                    pc_write = 1'b1;
                    pc_src   = zero_bit ? PC_SRC_BRANCH : PC_SRC_SEQ;
                end else if (ctl_mem_read || ctl_mem_write) begin
                    next_state = ST_MEM;
                end else if (ctl_reg_write) begin
                    next_state = ST_WB;
                end else begin
                    pc_write = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_read  = !mem_is_write_q;
                dmem_write = mem_is_write_q;
                if (dmem_ready) begin
                    if (mem_is_write_q) pc_write = 1'b1;
                    else                next_state = ST_WB;
                end else if (timeout) begin
                    next_state = ST_ERR;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            default: next_state = ST_ERR;
        endcase
        // Instruction boundary: the only place halt_req is honoured.
        if (pc_write) next_state = halt_req ? ST_HALT : ST_FETCH;
    end

    // State register plus the load/store direction captured as EXEC hands off to MEM.
    // NOTE: reset is asynchronous so strobes, all decoded from state, drop the instant reset_n falls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            mem_is_write_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (state_q == ST_EXEC) mem_is_write_q <= ctl_mem_write;
        end
    end

    assign waiting    = ((state_q == ST_FETCH) && !imem_ready) ||
                        ((state_q == ST_MEM)   && !dmem_ready);
    assign wait_clear = (next_state != state_q) &&
                        ((next_state == ST_FETCH) || (next_state == ST_MEM));

    mips_seq_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (wait_clear),
        .waiting(waiting),
        .timeout(timeout)
    );

`ifdef MIPS_SEQ_PERF_EN
    logic active;
    assign active = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERR);

    // Saturating performance counters: busy cycles and retired instructions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (active)   cycle_count <= sat_inc(cycle_count);
            if (pc_write) instr_count <= sat_inc(instr_count);
        end
    end
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Self-checking bench for mips_multicycle_sequencer: a scoreboard of expected
// instruction completions is checked by a monitor on every pc_write pulse.
module tb_mips_multicycle_sequencer;
    import mips_seq_pkg::*;

`ifdef MIPS_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, halt_req, imem_ready, dmem_ready;
    logic        ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_branch, ctl_jump, zero_bit;
    logic        imem_req, ir_write, dmem_read, dmem_write, reg_write, pc_write;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic        error;
    logic [31:0] instr_count, cycle_count;

    mips_multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .halt_req(halt_req),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write),
        .ctl_reg_write(ctl_reg_write), .ctl_branch(ctl_branch), .ctl_jump(ctl_jump),
        .zero_bit(zero_bit), .imem_req(imem_req), .ir_write(ir_write),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .reg_write(reg_write),
        .pc_write(pc_write), .pc_src(pc_src), .state(state), .error(error),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         t0;
        int         lat;
        logic [1:0] src;
        logic       rw;
        int         memcyc;
        int         instr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   ops_done = 0;
    int   imem_delay = 0;
    int   dmem_delay = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: raise ready after the configured number of wait cycles.
    initial begin : responder
        int icnt, dcnt;
        icnt = 0; dcnt = 0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (imem_req) begin imem_ready = (icnt >= imem_delay); icnt++; end
            else          begin imem_ready = 1'b0; icnt = 0; end
            if (dmem_read || dmem_write) begin dmem_ready = (dcnt >= dmem_delay); dcnt++; end
            else                         begin dmem_ready = 1'b0; dcnt = 0; end
        end
    end

    // Monitor: pop one expectation per instruction completion.
    initial begin : monitor
        int   mem_cyc;
        exp_t e;
        mem_cyc = 0;
        forever begin
            @(negedge clock);
            #1;
            if (!reset_n) begin
                mem_cyc = 0;
            end else begin
                if (dmem_read || dmem_write) mem_cyc++;
                if (reg_write && !pc_write) check("reg_write_without_pc_write", 32'(pc_write), 32'd1);
                if (pc_write) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_pc_write_queue_size", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
                        check("pc_src", 32'(pc_src), 32'(e.src));
                        check("reg_write_at_pc_write", 32'(reg_write), 32'(e.rw));
                        check("mem_strobe_cycles", 32'(mem_cyc), 32'(e.memcyc));
                        check("instr_count_at_pc_write", instr_count, 32'(e.instr));
                    end
                    mem_cyc = 0;
                end
            end
        end
    end

    // Issue one instruction; called just after the edge that enters FETCH.
    task automatic run_op(input logic j, input logic b, input logic mr, input logic mw,
                          input logic rw, input logic z, input logic h,
                          input int idly, input int ddly,
                          input int lat, input logic [1:0] src, input logic exp_rw,
                          input int memcyc);
        exp_t e;
        bit   done;
        ctl_jump = j; ctl_branch = b; ctl_mem_read = mr; ctl_mem_write = mw;
        ctl_reg_write = rw; zero_bit = z; halt_req = h;
        imem_delay = idly; dmem_delay = ddly;
        e.t0 = cyc; e.lat = lat; e.src = src; e.rw = exp_rw; e.memcyc = memcyc;
        e.instr = PERF ? ops_done : 0;
        sb_q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clock);
            #1;
            if (pc_write || error) done = 1'b1;
        end
        if (!done) check("op_completion_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        halt_req = 1'b0;
        ops_done++;
    endtask

    initial begin : stimulus
        bit seen;
        reset_n = 1'b0; start = 1'b0; halt_req = 1'b0;
        ctl_mem_read = 1'b0; ctl_mem_write = 1'b0; ctl_reg_write = 1'b0;
        ctl_branch = 1'b0; ctl_jump = 1'b0; zero_bit = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 32'(state), 32'(ST_IDLE));
        check("reset_error", 32'(error), 32'd0);
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_pc_write", 32'(pc_write), 32'd0);
        check("reset_instr_count", instr_count, 32'd0);
        check("reset_cycle_count", cycle_count, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("idle_hold", 32'(state), 32'(ST_IDLE));

        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("start_to_fetch", 32'(state), 32'(ST_FETCH));

        //     j  b  mr mw rw z  h  idly ddly lat src            rw mem
        run_op(0, 0, 0, 0, 1, 0, 0, 0,   0,   4,  PC_SRC_SEQ,    1, 0); // R-type
        check("instr_count_after_rtype", instr_count, PERF ? 32'd1 : 32'd0);
        run_op(0, 0, 1, 0, 1, 0, 0, 0,   3,   8,  PC_SRC_SEQ,    1, 4); // lw, 3 waits
        run_op(0, 1, 0, 0, 0, 1, 0, 0,   0,   3,  PC_SRC_BRANCH, 0, 0); // beq taken
        run_op(0, 1, 0, 0, 0, 0, 0, 0,   0,   3,  PC_SRC_SEQ,    0, 0); // beq not taken
        run_op(1, 0, 0, 0, 0, 0, 0, 0,   0,   3,  PC_SRC_JUMP,   0, 0); // j
        run_op(0, 0, 0, 0, 0, 0, 0, 0,   0,   3,  PC_SRC_SEQ,    0, 0); // nop
        run_op(0, 0, 0, 0, 1, 0, 0, 2,   0,   6,  PC_SRC_SEQ,    1, 0); // R-type, slow fetch
        run_op(0, 0, 0, 1, 0, 0, 1, 0,   0,   4,  PC_SRC_SEQ,    0, 1); // sw with halt_req

        check("halt_after_sw", 32'(state), 32'(ST_HALT));
        check("instr_count_total", instr_count, PERF ? 32'd8 : 32'd0);
        check("cycle_count_total", cycle_count, PERF ? 32'd34 : 32'd0);
        @(posedge clock); #1;
        check("halt_hold", 32'(state), 32'(ST_HALT));
        check("cycle_count_frozen_in_halt", cycle_count, PERF ? 32'd34 : 32'd0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("halt_start_to_fetch", 32'(state), 32'(ST_FETCH));

        // Reset while a store is stalled in MEM.
        ctl_mem_write = 1'b1; ctl_mem_read = 1'b0; ctl_reg_write = 1'b0;
        ctl_branch = 1'b0; ctl_jump = 1'b0;
        imem_delay = 0; dmem_delay = 1000;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock); #1;
            if (dmem_write) seen = 1'b1;
        end
        check("sw_reaches_mem", 32'(seen), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_mid_mem_dmem_write", 32'(dmem_write), 32'd0);
        check("reset_mid_mem_state", 32'(state), 32'(ST_IDLE));
        check("reset_mid_mem_pc_write", 32'(pc_write), 32'd0);
        check("reset_mid_mem_reg_write", 32'(reg_write), 32'd0);
        check("reset_mid_mem_instr_count", instr_count, 32'd0);
        check("reset_mid_mem_cycle_count", cycle_count, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        ctl_mem_write = 1'b0;
        dmem_delay = 0;

        // Load and store decoded together: no strobes in EXEC, then ERR.
        ctl_mem_read = 1'b1; ctl_mem_write = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("conflict_in_exec", 32'(state), 32'(ST_EXEC));
        check("conflict_no_strobes", 32'({pc_write, reg_write, dmem_read, dmem_write}), 32'd0);
        @(posedge clock); #1;
        check("conflict_to_err", 32'(state), 32'(ST_ERR));
        check("conflict_error_flag", 32'(error), 32'd1);
        ctl_mem_read = 1'b0; ctl_mem_write = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;

        // Instruction memory never ready: ERR on the 15th waiting cycle.
        imem_delay = 1000;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        check("fetch_cycle15_still_fetch", 32'(state), 32'(ST_FETCH));
        check("fetch_cycle15_imem_req", 32'(imem_req), 32'd1);
        @(posedge clock); #1;
        check("imem_timeout_state", 32'(state), 32'(ST_ERR));
        check("imem_timeout_error", 32'(error), 32'd1);
        check("imem_timeout_imem_req", 32'(imem_req), 32'd0);
        start = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b0;
        check("err_sticky_state", 32'(state), 32'(ST_ERR));
        check("err_sticky_strobes", 32'({imem_req, ir_write, pc_write, reg_write, dmem_read, dmem_write}), 32'd0);
        reset_n = 1'b0;
        #1;
        check("err_cleared_by_reset", 32'(error), 32'd0);
        reset_n = 1'b1;
        imem_delay = 0;

        repeat (2) @(posedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
